// File: rtl/l2_arb_pkg.sv
// Shared types and default field widths for the L2 lookup arbiter.
// Optional statistics counters are enabled in the top by defining L2_ARB_STATS_EN.
package l2_arb_pkg;

    localparam int unsigned L2_ADDR_W        = 32;
    localparam int unsigned L2_BYTE_SEL_BITS = 6;
    localparam int unsigned L2_INDEX_BITS    = 14;
    localparam int unsigned L2_TAG_BITS      = L2_ADDR_W - L2_INDEX_BITS - L2_BYTE_SEL_BITS;
    localparam int unsigned L2_CMD_W         = 4;

    typedef enum logic [L2_CMD_W-1:0] {
        RD_DATA    = 4'd0,
        WR_DATA    = 4'd1,
        RD_INSTR   = 4'd2,
        SNOOP_INV  = 4'd3,
        SNOOP_RD   = 4'd4,
        SNOOP_WR   = 4'd5,
        SNOOP_RWIM = 4'd6,
        CLEAR      = 4'd8,
        PRINT      = 4'd9
    } cmd_t;

    typedef struct packed {
        logic [L2_TAG_BITS-1:0]      tag;
        logic [L2_INDEX_BITS-1:0]    index;
        logic [L2_BYTE_SEL_BITS-1:0] byte_sel;
    } addr_fields_t;

    // Tag occupies the MSBs, so the packed struct is a direct overlay of the address.
    function automatic addr_fields_t split_addr(input logic [L2_ADDR_W-1:0] addr);
        return addr_fields_t'(addr);
    endfunction

endpackage

// File: rtl/l2_lookup_arbiter_picker.sv
// Combinational round-robin picker: first set bit of elig at or after ptr, with wrap.
module l2_rr_picker
    import l2_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]         elig,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] id,
    output logic                       any
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    int unsigned pos;

    always_comb begin
        gnt = '0;
        id  = '0;
        any = 1'b0;
        pos = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            pos = 32'(ptr) + off;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (!any && elig[ID_W'(pos)]) begin
                gnt[ID_W'(pos)] = 1'b1;
                id              = ID_W'(pos);
                any             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/l2_lookup_arbiter.sv
// Round-robin arbiter in front of the L2 tag-lookup pipeline with set-index conflict tracking.
// Define L2_ARB_STATS_EN to add grant_cnt / conflict_cnt statistics outputs.
module l2_lookup_arbiter
    import l2_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 3,
    parameter int unsigned ADDR_W        = L2_ADDR_W,
    parameter int unsigned BYTE_SEL_BITS = L2_BYTE_SEL_BITS,
    parameter int unsigned INDEX_BITS    = L2_INDEX_BITS,
    parameter int unsigned TAG_BITS      = L2_TAG_BITS,
    parameter int unsigned CMD_W         = L2_CMD_W,
    parameter int unsigned MAX_OUT       = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*CMD_W-1:0]    req_cmd,
    output logic                        lk_valid,
    input  logic                        lk_ready,
    output logic [TAG_BITS-1:0]         lk_tag,
    output logic [INDEX_BITS-1:0]       lk_index,
    output logic [BYTE_SEL_BITS-1:0]    lk_byte_sel,
    output logic [CMD_W-1:0]            lk_cmd,
    output logic [$clog2(NUM_REQ)-1:0]  lk_src,
    input  logic                        lk_done,
    output logic                        busy
`ifdef L2_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]       grant_cnt,
    output logic [31:0]                 conflict_cnt
`endif
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

    // In-order tracker of outstanding set indices; entry 0 is the oldest
    logic [INDEX_BITS-1:0] trk_idx   [MAX_OUT];
    logic [INDEX_BITS-1:0] trk_idx_n [MAX_OUT];
    logic [CNT_W-1:0]      trk_cnt, trk_cnt_n, wpos;
    logic [ID_W-1:0]       rr_ptr, rr_ptr_n;

    logic                     lk_valid_n, busy_n;
    logic [TAG_BITS-1:0]      lk_tag_n;
    logic [INDEX_BITS-1:0]    lk_index_n;
    logic [BYTE_SEL_BITS-1:0] lk_byte_sel_n;
    logic [CMD_W-1:0]         lk_cmd_n;
    logic [ID_W-1:0]          lk_src_n;

    logic [INDEX_BITS-1:0] req_index [NUM_REQ];
    logic [NUM_REQ-1:0]    conflict, bypass, elig, pick_gnt;
    logic [ID_W-1:0]       pick_id;
    logic                  pick_any, slot_free, stage_free, grant, pop;
    logic [ADDR_W-1:0]     win_addr;
    logic [CMD_W-1:0]      win_cmd;
    logic [INDEX_BITS-1:0] win_index;

    // Per-requester eligibility: clear/print skip the conflict mask
    always_comb begin
        conflict = '0;
        bypass   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_index[i] = req_addr[i*ADDR_W+BYTE_SEL_BITS +: INDEX_BITS];
            bypass[i]    = (req_cmd[i*CMD_W +: CMD_W] == CMD_W'(CLEAR)) ||
                           (req_cmd[i*CMD_W +: CMD_W] == CMD_W'(PRINT));
            for (int k = 0; k < MAX_OUT; k++) begin
                if ((CNT_W'(k) < trk_cnt) && (trk_idx[k] == req_index[i])) begin
                    conflict[i] = 1'b1;
                end
            end
            if (lk_valid && (lk_index == req_index[i])) begin
                conflict[i] = 1'b1;
            end
        end
        elig = req_valid & ~(conflict & ~bypass);
    end

    l2_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .elig (elig),
        .ptr  (rr_ptr),
        .gnt  (pick_gnt),
        .id   (pick_id),
        .any  (pick_any)
    );

    assign pop        = lk_done && (trk_cnt != '0);
    assign slot_free  = (trk_cnt < CNT_W'(MAX_OUT)) || pop;
    assign stage_free = !lk_valid || lk_ready;
    assign grant      = pick_any && slot_free && stage_free;
    assign req_ready  = grant ? pick_gnt : '0;

    // One-hot mux of the winning request
    always_comb begin
        win_addr = '0;
        win_cmd  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
                win_cmd  = req_cmd[i*CMD_W +: CMD_W];
            end
        end
        win_index = win_addr[BYTE_SEL_BITS +: INDEX_BITS];
    end

    // Next-state for tracker, output stage and round-robin pointer
    always_comb begin
        trk_idx_n     = trk_idx;
        trk_cnt_n     = trk_cnt;
        wpos          = trk_cnt;
        rr_ptr_n      = rr_ptr;
        lk_valid_n    = lk_valid;
        lk_tag_n      = lk_tag;
        lk_index_n    = lk_index;
        lk_byte_sel_n = lk_byte_sel;
        lk_cmd_n      = lk_cmd;
        lk_src_n      = lk_src;

        if (pop) begin
            for (int k = 0; k < MAX_OUT - 1; k++) begin
                trk_idx_n[k] = trk_idx[k+1];
            end
            trk_cnt_n = trk_cnt - CNT_W'(1);
            wpos      = trk_cnt - CNT_W'(1);
        end

        if (grant) begin
            for (int k = 0; k < MAX_OUT; k++) begin
                if (CNT_W'(k) == wpos) begin
                    trk_idx_n[k] = win_index;
                end
            end
            trk_cnt_n     = wpos + CNT_W'(1);
            rr_ptr_n      = (pick_id == ID_W'(NUM_REQ - 1)) ? '0 : pick_id + ID_W'(1);
            lk_valid_n    = 1'b1;
            lk_tag_n      = win_addr[INDEX_BITS+BYTE_SEL_BITS +: TAG_BITS];
            lk_index_n    = win_index;
            lk_byte_sel_n = win_addr[BYTE_SEL_BITS-1:0];
            lk_cmd_n      = win_cmd;
            lk_src_n      = pick_id;
        end else if (lk_ready) begin
            lk_valid_n = 1'b0;
        end

        busy_n = (trk_cnt_n != '0) || lk_valid_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < MAX_OUT; k++) begin
                trk_idx[k] <= '0;
            end
            trk_cnt     <= '0;
            rr_ptr      <= '0;
            lk_valid    <= 1'b0;
            lk_tag      <= '0;
            lk_index    <= '0;
            lk_byte_sel <= '0;
            lk_cmd      <= '0;
            lk_src      <= '0;
            busy        <= 1'b0;
        end else begin
            trk_idx     <= trk_idx_n;
            trk_cnt     <= trk_cnt_n;
            rr_ptr      <= rr_ptr_n;
            lk_valid    <= lk_valid_n;
            lk_tag      <= lk_tag_n;
            lk_index    <= lk_index_n;
            lk_byte_sel <= lk_byte_sel_n;
            lk_cmd      <= lk_cmd_n;
            lk_src      <= lk_src_n;
            busy        <= busy_n;
        end
    end

`ifdef L2_ARB_STATS_EN
    logic conflict_seen;
    assign conflict_seen = |(req_valid & conflict & ~bypass);

    // Saturating per-requester grant counts and conflict-cycle count
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt    <= '0;
            conflict_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant && pick_gnt[i] && (grant_cnt[i*32 +: 32] != 32'hFFFF_FFFF)) begin
                    grant_cnt[i*32 +: 32] <= grant_cnt[i*32 +: 32] + 32'd1;
                end
            end
            if (conflict_seen) begin
                conflict_cnt <= conflict_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_l2_lookup_arbiter.sv
// Table-driven self-checking bench for l2_lookup_arbiter with a queue scoreboard of lookups.
module tb_l2_lookup_arbiter;

    localparam logic [31:0] A5 = 32'h0000_0140;  // index 0x0005
    localparam logic [31:0] A7 = 32'h0000_01C0;  // index 0x0007
    localparam logic [31:0] A9 = 32'h0000_0240;  // index 0x0009
    localparam logic [31:0] AB = 32'h0000_02C0;  // index 0x000B
    localparam logic [31:0] AX = 32'h1234_5678;  // index 0x1159
    localparam logic [31:0] Z  = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_valid, req_ready;
    logic [95:0] req_addr;
    logic [11:0] req_cmd;
    logic        lk_valid, lk_ready, lk_done, busy;
    logic [11:0] lk_tag;
    logic [13:0] lk_index;
    logic [5:0]  lk_byte_sel;
    logic [3:0]  lk_cmd;
    logic [1:0]  lk_src;
`ifdef L2_ARB_STATS_EN
    logic [95:0] grant_cnt;
    logic [31:0] conflict_cnt;
`endif

    always #5 clk = ~clk;

    l2_lookup_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_cmd     (req_cmd),
        .lk_valid    (lk_valid),
        .lk_ready    (lk_ready),
        .lk_tag      (lk_tag),
        .lk_index    (lk_index),
        .lk_byte_sel (lk_byte_sel),
        .lk_cmd      (lk_cmd),
        .lk_src      (lk_src),
        .lk_done     (lk_done),
        .busy        (busy)
`ifdef L2_ARB_STATS_EN
        ,
        .grant_cnt   (grant_cnt),
        .conflict_cnt(conflict_cnt)
`endif
    );

    typedef struct {
        bit         rst;
        logic [2:0] valid;
        logic [31:0] a0, a1, a2;
        logic [3:0] c0, c1, c2;
        logic       rdy, done;
        logic [2:0] exp_ready;
        logic       exp_lkv, exp_busy;
    } vec_t;

    typedef struct {
        logic [11:0] tag;
        logic [13:0] index;
        logic [5:0]  bs;
        logic [3:0]  cmd;
        logic [1:0]  src;
    } lk_exp_t;

    localparam int NV = 27;
    vec_t    vt [NV];
    lk_exp_t sb [$];
    lk_exp_t last;
    int      n_chk  = 0;
    int      n_fail = 0;

    function automatic vec_t mk(input bit rst, input logic [2:0] valid,
                                input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                                input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2,
                                input logic rdy, input logic done,
                                input logic [2:0] er, input logic el, input logic eb);
        vec_t v;
        v.rst = rst; v.valid = valid; v.a0 = a0; v.a1 = a1; v.a2 = a2;
        v.c0 = c0; v.c1 = c1; v.c2 = c2; v.rdy = rdy; v.done = done;
        v.exp_ready = er; v.exp_lkv = el; v.exp_busy = eb;
        return v;
    endfunction

    function automatic lk_exp_t exp_rec(input vec_t v);
        lk_exp_t     e;
        logic [31:0] a;
        a = v.exp_ready[0] ? v.a0 : (v.exp_ready[1] ? v.a1 : v.a2);
        e.cmd   = v.exp_ready[0] ? v.c0 : (v.exp_ready[1] ? v.c1 : v.c2);
        e.src   = v.exp_ready[0] ? 2'd0 : (v.exp_ready[1] ? 2'd1 : 2'd2);
        e.tag   = a[31:20];
        e.index = a[19:6];
        e.bs    = a[5:0];
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_fields(input int i, input lk_exp_t e);
        chk($sformatf("v%0d lk_tag", i),      32'(lk_tag),      32'(e.tag));
        chk($sformatf("v%0d lk_index", i),    32'(lk_index),    32'(e.index));
        chk($sformatf("v%0d lk_byte_sel", i), 32'(lk_byte_sel), 32'(e.bs));
        chk($sformatf("v%0d lk_cmd", i),      32'(lk_cmd),      32'(e.cmd));
        chk($sformatf("v%0d lk_src", i),      32'(lk_src),      32'(e.src));
    endtask

    task automatic idle_inputs();
        req_valid = '0; req_addr = '0; req_cmd = '0; lk_ready = 1'b1; lk_done = 1'b0;
    endtask

    // Entered at a negedge; leaves at the following negedge after checking registered outputs
    task automatic run_vec(input int i);
        vec_t v;
        v = vt[i];
        if (v.rst) begin
            idle_inputs();
            reset = 1'b1;
            repeat (2) @(negedge clk);
            reset = 1'b0;
            chk($sformatf("v%0d rst lk_valid", i), 32'(lk_valid), 32'd0);
            chk($sformatf("v%0d rst busy", i),     32'(busy),     32'd0);
            last = '{tag: '0, index: '0, bs: '0, cmd: '0, src: '0};
            chk_fields(i, last);
        end
        req_valid = v.valid;
        req_addr  = {v.a2, v.a1, v.a0};
        req_cmd   = {v.c2, v.c1, v.c0};
        lk_ready  = v.rdy;
        lk_done   = v.done;
        #1;
        chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(v.exp_ready));
        chk($sformatf("v%0d ready_onehot", i), 32'($countones(req_ready) <= 1), 32'd1);
        if (v.exp_ready != 3'b000) sb.push_back(exp_rec(v));
        @(negedge clk);
        chk($sformatf("v%0d lk_valid", i), 32'(lk_valid), 32'(v.exp_lkv));
        chk($sformatf("v%0d busy", i),     32'(busy),     32'(v.exp_busy));
        if (v.exp_ready != 3'b000) last = sb.pop_front();
        if (v.exp_lkv) chk_fields(i, last);
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();

        // Round robin with lk_done every cycle (done on empty tracker ignored)
        vt[0]  = mk(1, 3'b111, A5, AX, A7, 4'd0, 4'd2, 4'd4, 1, 1, 3'b001, 1, 1);
        vt[1]  = mk(0, 3'b111, A5, AX, A7, 4'd0, 4'd2, 4'd4, 1, 1, 3'b010, 1, 1);
        vt[2]  = mk(0, 3'b111, A5, AX, A7, 4'd0, 4'd2, 4'd4, 1, 1, 3'b100, 1, 1);
        vt[3]  = mk(0, 3'b111, A5, AX, A7, 4'd0, 4'd2, 4'd4, 1, 1, 3'b001, 1, 1);
        vt[4]  = mk(0, 3'b111, A5, AX, A7, 4'd0, 4'd2, 4'd4, 1, 1, 3'b010, 1, 1);
        vt[5]  = mk(0, 3'b111, A5, AX, A7, 4'd0, 4'd2, 4'd4, 1, 1, 3'b100, 1, 1);
        vt[6]  = mk(0, 3'b000, Z,  Z,  Z,  4'd0, 4'd0, 4'd0, 1, 1, 3'b000, 0, 0);
        // Index conflict: req 0 masked while 0x5 in flight, req 2 overtakes
        vt[7]  = mk(0, 3'b001, A5, Z,  Z,  4'd0, 4'd0, 4'd0, 1, 0, 3'b001, 1, 1);
        vt[8]  = mk(0, 3'b101, A5, Z,  A7, 4'd0, 4'd0, 4'd4, 1, 0, 3'b100, 1, 1);
        vt[9]  = mk(0, 3'b101, A5, Z,  A7, 4'd0, 4'd0, 4'd4, 1, 0, 3'b000, 0, 1);
        vt[10] = mk(0, 3'b001, A5, Z,  Z,  4'd0, 4'd0, 4'd0, 1, 1, 3'b000, 0, 1);
        vt[11] = mk(0, 3'b001, A5, Z,  Z,  4'd0, 4'd0, 4'd0, 1, 0, 3'b001, 1, 1);
        vt[12] = mk(0, 3'b000, Z,  Z,  Z,  4'd0, 4'd0, 4'd0, 1, 1, 3'b000, 0, 1);
        vt[13] = mk(0, 3'b000, Z,  Z,  Z,  4'd0, 4'd0, 4'd0, 1, 1, 3'b000, 0, 0);
        // Output stall for 4 cycles, then release
        vt[14] = mk(0, 3'b010, Z,  AX, Z,  4'd0, 4'd2, 4'd0, 0, 0, 3'b010, 1, 1);
        vt[15] = mk(0, 3'b101, A9, Z,  AB, 4'd1, 4'd0, 4'd5, 0, 0, 3'b000, 1, 1);
        vt[16] = mk(0, 3'b101, A9, Z,  AB, 4'd1, 4'd0, 4'd5, 0, 0, 3'b000, 1, 1);
        vt[17] = mk(0, 3'b101, A9, Z,  AB, 4'd1, 4'd0, 4'd5, 0, 0, 3'b000, 1, 1);
        vt[18] = mk(0, 3'b101, A9, Z,  AB, 4'd1, 4'd0, 4'd5, 0, 0, 3'b000, 1, 1);
        vt[19] = mk(0, 3'b101, A9, Z,  AB, 4'd1, 4'd0, 4'd5, 1, 0, 3'b100, 1, 1);
        // Tracker full, then lk_done frees a slot for a same-cycle grant
        vt[20] = mk(0, 3'b001, A9, Z,  Z,  4'd1, 4'd0, 4'd0, 1, 0, 3'b000, 0, 1);
        vt[21] = mk(0, 3'b001, A9, Z,  Z,  4'd1, 4'd0, 4'd0, 1, 1, 3'b001, 1, 1);
        vt[22] = mk(0, 3'b000, Z,  Z,  Z,  4'd0, 4'd0, 4'd0, 1, 1, 3'b000, 0, 1);
        vt[23] = mk(0, 3'b000, Z,  Z,  Z,  4'd0, 4'd0, 4'd0, 1, 1, 3'b000, 0, 0);
        // CLEAR bypasses conflict but takes a slot; then reset with full tracker
        vt[24] = mk(0, 3'b010, Z,  A5, Z,  4'd0, 4'd0, 4'd0, 1, 0, 3'b010, 1, 1);
        vt[25] = mk(0, 3'b001, A5, Z,  Z,  4'd8, 4'd0, 4'd0, 1, 0, 3'b001, 1, 1);
        vt[26] = mk(1, 3'b110, Z,  A7, A9, 4'd0, 4'd2, 4'd3, 1, 0, 3'b010, 1, 1);

        @(negedge clk);
        for (int i = 0; i < NV; i++) begin
            run_vec(i);
            if (i == 1) begin
                chk("addr_split tag",      32'(lk_tag),      32'h123);
                chk("addr_split index",    32'(lk_index),    32'h1159);
                chk("addr_split byte_sel", 32'(lk_byte_sel), 32'h38);
                chk("addr_split src",      32'(lk_src),      32'd1);
            end
        end
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
